// File: rtl/xaddsubt_arb_if.sv
// Bundle of requester, hold and result signals for the shared add/sub arbiter.
// master: requester side (drives requests/operands/hold, observes grant/result).
// slave: arbiter side (observes requests, drives grant/result/status).
interface xaddsubt_arb_if #(
   parameter int BWID = 16,
   parameter int NREQ = 4
);
   localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

   logic [NREQ-1:0]      iv_req;
   logic [NREQ-1:0]      iv_sub;
   logic [NREQ*BWID-1:0] iv_a;
   logic [NREQ*BWID-1:0] iv_b;
   logic                 i_hold;
   logic [NREQ-1:0]      ov_gnt;
   logic [BWID-1:0]      ov_res;
   logic [IDW-1:0]       ov_id;
   logic                 o_dv;
   logic [NREQ-1:0]      ov_dv;
   logic [15:0]          ov_issue_cnt;
   logic                 o_busy;

   modport master (
      output iv_req, iv_sub, iv_a, iv_b, i_hold,
      input  ov_gnt, ov_res, ov_id, o_dv, ov_dv, ov_issue_cnt, o_busy
   );

   modport slave (
      input  iv_req, iv_sub, iv_a, iv_b, i_hold,
      output ov_gnt, ov_res, ov_id, o_dv, ov_dv, ov_issue_cnt, o_busy
   );
endinterface

// File: rtl/xaddsubt_arb.sv
// Round-robin arbiter feeding one shared LATENCY-stage registered add/sub pipeline.
// Latency: grant in cycle t -> result with one-hot valid in cycle t+LATENCY.
// Backpressure: none downstream; i_hold suppresses grants while the pipeline drains.
// Ports: clk, i_rst_n (async active-low), bus (slave side of xaddsubt_arb_if).
module xaddsubt_arb #(
   parameter int BWID    = 16,
   parameter int NREQ    = 4,
   parameter int LATENCY = 1
) (
   input  logic          clk,
   input  logic          i_rst_n,
   xaddsubt_arb_if.slave bus
);
   localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

   logic [IDW-1:0]  rr_ptr;
   logic [NREQ-1:0] gnt;
   logic [IDW-1:0]  gnt_id;
   logic            found;
   logic            issue;
   logic [BWID-1:0] sel_a;
   logic [BWID-1:0] sel_b;
   logic [BWID-1:0] sel_res;
   logic            sel_sub;

   logic [BWID-1:0] res_q [LATENCY];
   logic [IDW-1:0]  id_q  [LATENCY];
   logic [LATENCY-1:0] vld_q;
   logic [15:0]     issue_cnt;
   logic [NREQ-1:0] dv_oh;

   // Rotating search starting at rr_ptr; first pending requester wins.
   always_comb begin
      int idx;
      found  = 1'b0;
      gnt_id = '0;
      gnt    = '0;
      for (int i = 0; i < NREQ; i++) begin
         idx = int'(rr_ptr) + i;
         if (idx >= NREQ) idx = idx - NREQ;
         if (!found && bus.iv_req[idx]) begin
            found  = 1'b1;
            gnt_id = IDW'(idx);
         end
      end
      // Reset is included so no grant is reported while state is held cleared.
      if (found && !bus.i_hold && i_rst_n) gnt[gnt_id] = 1'b1;
   end

   assign issue   = |gnt;
   assign sel_a   = bus.iv_a[gnt_id*BWID +: BWID];
   assign sel_b   = bus.iv_b[gnt_id*BWID +: BWID];
   assign sel_sub = bus.iv_sub[gnt_id];
   // Carry/borrow fall off the top; results wrap mod 2^BWID.
   assign sel_res = sel_sub ? (sel_a - sel_b) : (sel_a + sel_b);

   always_ff @(posedge clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         rr_ptr    <= '0;
         issue_cnt <= '0;
         vld_q     <= '0;
         for (int s = 0; s < LATENCY; s++) begin
            res_q[s] <= '0;
            id_q[s]  <= '0;
         end
      end else begin
         if (issue) begin
            rr_ptr    <= (gnt_id == IDW'(NREQ - 1)) ? '0 : gnt_id + 1'b1;
            issue_cnt <= issue_cnt + 16'd1;
         end
         // Operation is computed at issue; later stages only carry it along.
         res_q[0] <= sel_res;
         id_q[0]  <= gnt_id;
         vld_q[0] <= issue;
         for (int s = 1; s < LATENCY; s++) begin
            res_q[s] <= res_q[s-1];
            id_q[s]  <= id_q[s-1];
            vld_q[s] <= vld_q[s-1];
         end
      end
   end

   always_comb begin
      dv_oh = '0;
      if (vld_q[LATENCY-1]) dv_oh[id_q[LATENCY-1]] = 1'b1;
   end

   assign bus.ov_gnt       = gnt;
   assign bus.ov_res       = res_q[LATENCY-1];
   assign bus.ov_id        = id_q[LATENCY-1];
   assign bus.o_dv         = vld_q[LATENCY-1];
   assign bus.ov_dv        = dv_oh;
   assign bus.ov_issue_cnt = issue_cnt;
   assign bus.o_busy       = |vld_q;
endmodule

// File: doc/xaddsubt_arb.md
# xaddsubt_arb

Round-robin scheduler that shares one pipelined add/subtract datapath among NREQ requesters. Each cycle it grants at most one pending request, issues that requester's operand pair and operation into a LATENCY-stage registered add/sub pipeline, and carries the requester ID alongside the data. Results return with a one-hot per-requester valid. It sits between several DSP lanes that need occasional add/sub operations and a single shared arithmetic resource.

## Interface
Parameters:
- BWID, 16, operand and result width
- NREQ, 4, number of requesters (≥1)
- LATENCY, 1, pipeline depth in clocks from issue edge to result (≥1)
- IDW, localparam = max(1, clog2(NREQ)), requester ID width

Ports:
- clk  in  1  clock, all state on rising edge
- i_rst_n  in  1  asynchronous active-low reset
- iv_req  in  NREQ  request per requester; held high until granted
- iv_sub  in  NREQ  op select per requester: 0 = a+b, 1 = a−b
- iv_a  in  NREQ*BWID  operand a, requester k at bits [k*BWID +: BWID]
- iv_b  in  NREQ*BWID  operand b, same packing
- i_hold  in  1  1 = issue no grants (pipeline keeps draining)
- ov_gnt  out  NREQ  one-hot grant, combinational, same cycle as request
- ov_res  out  BWID  result
- ov_id  out  IDW  requester ID of ov_res
- o_dv  out  1  result valid
- ov_dv  out  NREQ  one-hot result valid (bit ov_id set when o_dv)
- ov_issue_cnt  out  16  total grants issued, wraps mod 2^16
- o_busy  out  1  any operation in flight

## Operation
- Transfer: requester k is issued in any cycle where iv_req[k] & ov_gnt[k].
- Arbitration: rr_ptr (IDW bits) marks the highest-priority requester. Search runs rr_ptr, rr_ptr+1, …, wrapping mod NREQ; the first requester with iv_req set is granted.
- ov_gnt = 0 when i_hold = 1, when iv_req = 0, or while i_rst_n = 0.
- After a grant to k, rr_ptr ← (k+1) mod NREQ. With no grant, rr_ptr is unchanged. For NREQ = 1, rr_ptr stays 0.
- Issue stage: on the edge that ends the grant cycle, the pipeline captures the selected a, b, sub, id and valid = 1. With no grant it captures valid = 0; data is don't-care internally.
- Arithmetic: sum = a+b, diff = a−b, both mod 2^BWID. Carry and borrow are discarded and there is no saturation. ov_res carries the result selected by the captured sub bit.
- The pipeline never stalls: at most one issue per cycle, and results are delivered in issue order.
- ov_dv = o_dv ? (1 << ov_id) : 0.
- o_busy = OR of all pipeline valid bits. It does not include the current combinational grant.
- ov_issue_cnt increments by 1 on every transfer and wraps 0xFFFF→0x0000.
- Requester obligation: iv_a, iv_b and iv_sub for requester k are stable while iv_req[k] is high and not yet granted. Dropping iv_req before a grant withdraws the request with no side effect.

## Timing
- Reset values: rr_ptr = 0, all pipeline valid = 0, ov_res = 0, ov_id = 0, o_dv = 0, ov_dv = 0, ov_issue_cnt = 0, o_busy = 0. ov_gnt = 0 during reset.
- Latency: a grant in cycle t gives o_dv = 1 with the matching ov_res and ov_id in cycle t+LATENCY. Example: LATENCY = 1, so the result appears in the cycle after the grant.
- Back-to-back: grants in consecutive cycles produce results in consecutive cycles. Sustained throughput is 1 result/clk.
- i_hold asserted mid-stream: grants stop in the same cycle. Results already issued still emerge on schedule, and o_busy falls LATENCY cycles after the last issue.
- Simultaneous requests: only one grant per cycle. Losers keep iv_req high and are served in round-robin order.
- Reset asserted mid-operation: all in-flight operations are discarded immediately (asynchronous). No o_dv is produced for them after release.
- The first grant after reset release goes to the lowest-index requester at or above rr_ptr = 0.

## Test plan
- NREQ=4, LATENCY=1, only req0 high, a=0x0005, b=0x0003, sub=0 → gnt=0001 in cycle 0; cycle 1: o_dv=1, ov_res=0x0008, ov_id=0, ov_dv=0001; issue_cnt=1.
- All four requesters held high for 8 cycles → grant order 0,1,2,3,0,1,2,3. ov_id follows the same order one cycle later; issue_cnt=8.
- Wrap arithmetic: a=0xFFFF, b=0x0002, sub=0 → ov_res=0x0001. a=0x0000, b=0x0001, sub=1 → ov_res=0xFFFF.
- LATENCY=3, req1 then req2 in consecutive cycles, then i_hold=1 → two results at t+3 and t+4 with ids 1 and 2. No grants during hold; o_busy is 0 from t+5.
- Pulse i_rst_n low one cycle after issuing two ops with LATENCY=3 → no o_dv ever appears. Post-reset, req3 and req0 both high grants req0 first (rr_ptr=0); issue_cnt restarts at 0.
- Preset issue_cnt to 0xFFFF via 65535 grants, then one more grant → 0x0000.
